// File: rtl/ib_v2c_pipeline_gen.sv
// v2c message pipeline: STAGES register stages with stall, flush and
// per-channel masking; tracks how many stages hold a valid word.
module ib_v2c_pipeline_gen #(
  parameter int QUAN_SIZE = 4,
  parameter int CHANNEL_NUM = 6,
  parameter int PIPELINE_DEPTH = 3,
  parameter logic [CHANNEL_NUM-1:0] CH_MASK = '1,
  localparam int OCC_W = $clog2(PIPELINE_DEPTH)
) (
  input  logic read_clk,
  input  logic rstn,
  input  logic [CHANNEL_NUM*QUAN_SIZE-1:0] v2c_in,
  input  logic v2c_valid_in,
  input  logic pipe_en,
  input  logic flush,
  output logic [CHANNEL_NUM*QUAN_SIZE-1:0] M_reg,
  output logic v2c_valid_out,
  output logic [OCC_W-1:0] pipe_occupancy,
  output logic pipe_empty
);

  localparam int STAGES = PIPELINE_DEPTH - 1;
  localparam int Q = QUAN_SIZE;

  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] vld_nxt;
  logic [STAGES:0] vld_sh;
  logic [OCC_W-1:0] occ_nxt;

  assign vld_sh = {vld, v2c_valid_in};

  always_comb begin
    vld_nxt = vld;
    if (flush)
      vld_nxt = '0;
    else if (pipe_en)
      vld_nxt = vld_sh[STAGES-1:0];
  end

  always_comb begin
    occ_nxt = '0;
    for (int k = 0; k < STAGES; k++)
      occ_nxt = occ_nxt + OCC_W'(vld_nxt[k]);
  end

  always_ff @(posedge read_clk or negedge rstn) begin
    if (!rstn) begin
      vld <= '0;
      pipe_occupancy <= '0;
    end else begin
      vld <= vld_nxt;
      pipe_occupancy <= occ_nxt;
    end
  end

  assign v2c_valid_out = vld[STAGES-1];
  assign pipe_empty = (pipe_occupancy == '0);

  for (genvar i = 0; i < CHANNEL_NUM; i++) begin : g_ch
    if (CH_MASK[i]) begin : g_on
      logic [STAGES*Q-1:0] pipe;
      logic [(STAGES+1)*Q-1:0] sh;

      // stage 0 sits in the low slice; each shift moves stage k-1 into k
      assign sh = {pipe, v2c_in[i*Q +: Q]};

      always_ff @(posedge read_clk or negedge rstn) begin
        if (!rstn)
          pipe <= '0;
        else if (flush)
          pipe <= '0;
        else if (pipe_en)
          pipe <= sh[STAGES*Q-1:0];
      end

      assign M_reg[i*Q +: Q] = pipe[(STAGES-1)*Q +: Q];
    end else begin : g_off
      logic unused_ch;
      assign unused_ch = ^v2c_in[i*Q +: Q];
      assign M_reg[i*Q +: Q] = '0;
    end
  end

endmodule

// File: tb/tb_ib_v2c_pipeline_gen.sv
// Bench for ib_v2c_pipeline_gen: full-mask and 6'b011011-mask instances
// driven in parallel; output words checked from expected-value queues.
module tb_ib_v2c_pipeline_gen;

  logic read_clk = 1'b0;
  logic rstn = 1'b1;
  logic [23:0] v2c_in = '0;
  logic v2c_valid_in = 1'b0;
  logic pipe_en = 1'b0;
  logic flush = 1'b0;

  logic [23:0] m_a, m_b;
  logic vo_a, vo_b;
  logic [1:0] occ_a, occ_b;
  logic emp_a, emp_b;

  int total = 0;
  int bad = 0;

  logic [23:0] q_a[$];
  logic [23:0] q_b[$];
  logic adv_q = 1'b0;

  always #5 read_clk = ~read_clk;

  ib_v2c_pipeline_gen dut_a (
    .read_clk(read_clk), .rstn(rstn),
    .v2c_in(v2c_in), .v2c_valid_in(v2c_valid_in),
    .pipe_en(pipe_en), .flush(flush),
    .M_reg(m_a), .v2c_valid_out(vo_a),
    .pipe_occupancy(occ_a), .pipe_empty(emp_a)
  );

  ib_v2c_pipeline_gen #(.CH_MASK(6'b011011)) dut_b (
    .read_clk(read_clk), .rstn(rstn),
    .v2c_in(v2c_in), .v2c_valid_in(v2c_valid_in),
    .pipe_en(pipe_en), .flush(flush),
    .M_reg(m_b), .v2c_valid_out(vo_b),
    .pipe_occupancy(occ_b), .pipe_empty(emp_b)
  );

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // an output word counts once, on the edge that moved it into the last stage
  always @(posedge read_clk)
    adv_q <= rstn & pipe_en & ~flush;

  always @(negedge read_clk) begin
    if (rstn && adv_q && vo_a) begin
      if (q_a.size() == 0)
        chk("unexpected_a", {8'h0, m_a}, 32'hDEAD);
      else
        chk("word_a", {8'h0, m_a}, {8'h0, q_a.pop_front()});
    end
    if (rstn && adv_q && vo_b) begin
      if (q_b.size() == 0)
        chk("unexpected_b", {8'h0, m_b}, 32'hDEAD);
      else
        chk("word_b", {8'h0, m_b}, {8'h0, q_b.pop_front()});
    end
  end

  task automatic step();
    @(posedge read_clk);
    #1;
  endtask

  task automatic drive(logic [23:0] d, logic v, logic [23:0] ea, logic [23:0] eb);
    v2c_in = d;
    v2c_valid_in = v;
    if (v && pipe_en && !flush && rstn) begin
      q_a.push_back(ea);
      q_b.push_back(eb);
    end
  endtask

  task automatic idle();
    drive(24'h0, 1'b0, 24'h0, 24'h0);
  endtask

  task automatic chk_state(string nm, logic [23:0] m, logic vo, logic [1:0] occ);
    chk({nm, "_m"}, {8'h0, m_a}, {8'h0, m});
    chk({nm, "_vo"}, {31'h0, vo_a}, {31'h0, vo});
    chk({nm, "_occ"}, {30'h0, occ_a}, {30'h0, occ});
    chk({nm, "_empty"}, {31'h0, emp_a}, {31'h0, occ == 2'd0});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rstn = 1'b0;
    v2c_in = 24'($urandom);
    v2c_valid_in = 1'b1;
    pipe_en = 1'b1;
    #2;
    chk_state("rst_async", 24'h0, 1'b0, 2'd0);
    chk("rst_b_m", {8'h0, m_b}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      v2c_in = 24'($urandom);
      v2c_valid_in = 1'($urandom);
      flush = 1'($urandom);
    end
    chk_state("rst_held", 24'h0, 1'b0, 2'd0);

    flush = 1'b0;
    pipe_en = 1'b1;
    idle();
    rstn = 1'b1;

    // latency: one word, two enabled edges
    drive(24'h543210, 1'b1, 24'h543210, 24'h043010);
    step();
    idle();
    chk_state("lat_e0", 24'h0, 1'b0, 2'd1);
    step();
    chk_state("lat_e1", 24'h543210, 1'b1, 2'd1);
    chk("lat_b_m", {8'h0, m_b}, 32'h043010);
    step();
    chk_state("lat_e2", 24'h0, 1'b0, 2'd0);

    // stall with two words in flight
    drive(24'h111111, 1'b1, 24'h111111, 24'h011011);
    step();
    drive(24'h222222, 1'b1, 24'h222222, 24'h022022);
    step();
    chk_state("stall_pre", 24'h111111, 1'b1, 2'd2);
    pipe_en = 1'b0;
    idle();
    for (int i = 0; i < 3; i++) begin
      step();
      chk_state("stall_hold", 24'h111111, 1'b1, 2'd2);
    end
    pipe_en = 1'b1;
    step();
    chk_state("stall_res1", 24'h222222, 1'b1, 2'd1);
    step();
    chk_state("stall_res2", 24'h0, 1'b0, 2'd0);

    // flush beats pipe_en and a valid input
    drive(24'hAAAAAA, 1'b1, 24'hAAAAAA, 24'h0AA0AA);
    step();
    drive(24'hBBBBBB, 1'b1, 24'hBBBBBB, 24'h0BB0BB);
    step();
    chk("flush_pre_occ", {30'h0, occ_a}, 32'd2);
    flush = 1'b1;
    drive(24'hCCCCCC, 1'b1, 24'h0, 24'h0);
    step();
    q_a.delete();
    q_b.delete();
    flush = 1'b0;
    idle();
    chk_state("flush", 24'h0, 1'b0, 2'd0);
    chk("flush_b_m", {8'h0, m_b}, 32'h0);

    // masked channels read zero
    for (int i = 0; i < 3; i++) begin
      drive(24'hFFFFFF, 1'b1, 24'hFFFFFF, 24'h0FF0FF);
      step();
    end
    idle();
    chk("mask_b_m", {8'h0, m_b}, 32'h0FF0FF);
    chk("mask_a_m", {8'h0, m_a}, 32'hFFFFFF);
    chk("mask_b_occ", {30'h0, occ_b}, 32'd2);
    step();
    step();
    chk("mask_drain", {30'h0, occ_b}, 32'd0);

    // asynchronous reset between edges
    drive(24'h123456, 1'b1, 24'h123456, 24'h023056);
    step();
    drive(24'h654321, 1'b1, 24'h654321, 24'h054021);
    step();
    chk("arst_pre_occ", {30'h0, occ_a}, 32'd2);
    idle();
    #1 rstn = 1'b0;
    q_a.delete();
    q_b.delete();
    #1;
    chk_state("arst", 24'h0, 1'b0, 2'd0);
    chk("arst_b_m", {8'h0, m_b}, 32'h0);
    rstn = 1'b1;
    step();
    drive(24'h9ABCDE, 1'b1, 24'h9ABCDE, 24'h0AB0DE);
    step();
    idle();
    chk_state("arst_e0", 24'h0, 1'b0, 2'd1);
    step();
    chk_state("arst_e1", 24'h9ABCDE, 1'b1, 2'd1);
    step();
    step();
    chk("q_a_left", q_a.size(), 32'd0);
    chk("q_b_left", q_b.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ib_v2c_pipeline_gen.md
IB_V2C_PIPELINE_GEN -- requirements
Module: ib_v2c_pipeline_gen

Interface
REQ-001 SHALL have parameter QUAN_SIZE, default 4: bit width of one v2c message.
REQ-002 SHALL have parameter CHANNEL_NUM, default 6: number of v2c channels (CN degree).
REQ-003 SHALL have parameter PIPELINE_DEPTH, default 3: number of pipeline stages; STAGES = PIPELINE_DEPTH-1 register stages are built; legal range 2..16.
REQ-004 SHALL have parameter CH_MASK, width CHANNEL_NUM, default all-ones: bit i=1 means channel i is registered; bit i=0 means channel i is not built.
REQ-005 SHALL define local OCC_W = $clog2(PIPELINE_DEPTH).
REQ-006 SHALL have port read_clk  input  1  the only clock; all state updates on its rising edge.
REQ-007 SHALL have port rstn  input  1  reset, asynchronous and active-low.
REQ-008 SHALL have port v2c_in  input  CHANNEL_NUM*QUAN_SIZE  packed messages; channel i is at [i*QUAN_SIZE +: QUAN_SIZE].
REQ-009 SHALL have port v2c_valid_in  input  1  qualifies v2c_in.
REQ-010 SHALL have port pipe_en  input  1  1 = advance all stages; 0 = hold all stages.
REQ-011 SHALL have port flush  input  1  synchronous clear of all stages.
REQ-012 SHALL have port M_reg  output  CHANNEL_NUM*QUAN_SIZE  last-stage messages, same packing as v2c_in.
REQ-013 SHALL have port v2c_valid_out  output  1  valid bit of the last stage.
REQ-014 SHALL have port pipe_occupancy  output  OCC_W  number of stages currently holding a valid bit.
REQ-015 SHALL have port pipe_empty  output  1  high when pipe_occupancy==0.

Function
REQ-016 SHALL keep, per enabled channel and per stage k (0..STAGES-1), a QUAN_SIZE data register, plus one valid bit per stage shared by all channels.
REQ-017 SHALL, on a rising edge with flush=0 and pipe_en=1, load stage0 data <= v2c_in and valid0 <= v2c_valid_in, and load stage k <= stage k-1 (data and valid).
REQ-018 SHALL, on a rising edge with flush=0 and pipe_en=0, leave every data and valid register unchanged (stall).
REQ-019 SHALL, on a rising edge with flush=1, clear every valid bit and every data register to 0, regardless of pipe_en or v2c_valid_in; flush has priority.
REQ-020 SHALL make the latency from v2c_in to M_reg exactly STAGES enabled edges; stalled edges do not count.
REQ-021 SHALL drive M_reg from the last-stage data whether v2c_valid_out is 0 or 1; the output is not gated by valid.
REQ-022 SHALL drive the M_reg slice of every channel with CH_MASK bit 0 to a constant 0, with no register inferred for that channel.
REQ-023 SHALL register pipe_occupancy, with next value = popcount of the next-state valid bits; it never exceeds STAGES.
REQ-024 SHALL, on a simultaneous valid entry and valid exit with pipe_en=1, leave pipe_occupancy unchanged.
REQ-025 SHALL have no handshake back-pressure; an upstream producer must not present new data while pipe_en=0, and such data is dropped.

Reset
REQ-026 SHALL, while rstn=0, asynchronously force every data register, valid bit and pipe_occupancy to 0; M_reg=0, v2c_valid_out=0, pipe_occupancy=0 and pipe_empty=1, without waiting for a clock edge.
REQ-027 SHALL, when rstn deasserts, act on the first rising edge after deassertion, following REQ-017 to REQ-019.
REQ-028 SHALL, when reset is asserted mid-operation, lose all in-flight data, with no partial state surviving.

Verification (QUAN_SIZE=4, CHANNEL_NUM=6, PIPELINE_DEPTH=3, so STAGES=2)
REQ-029 SHALL cover reset: rstn=0 with random inputs -> M_reg=24'h0, v2c_valid_out=0, pipe_occupancy=0, pipe_empty=1.
REQ-030 SHALL cover latency: pipe_en=1; v2c_in=24'h543210 with valid=1 at edge 0, then valid=0 -> after edge 0 pipe_occupancy=1; after edge 1 M_reg=24'h543210, v2c_valid_out=1, occupancy=1; after edge 2 v2c_valid_out=0, pipe_empty=1.
REQ-031 SHALL cover stall: two valid words 24'h111111 and 24'h222222 in flight, then pipe_en=0 for 3 edges -> M_reg, v2c_valid_out and occupancy=2 all frozen; on resume the words emerge in order, one per edge.
REQ-032 SHALL cover flush priority: occupancy=2, then flush=1, pipe_en=1, v2c_valid_in=1 on one edge -> next cycle occupancy=0, M_reg=0, v2c_valid_out=0.
REQ-033 SHALL cover masking: CH_MASK=6'b011011 and v2c_in=24'hFFFFFF streamed -> M_reg=24'h0FF0FF; channels 2 and 5 read 0.
REQ-034 SHALL cover asynchronous mid-flight reset: rstn pulsed low between clock edges while occupancy=2 -> outputs read 0 before the next edge; after release, a new word appears after 2 edges.
